wb_stage: RTL and testbench

- Writeback stage directly downstream of the execute stage.
- Captures completed results from the ALU, SFU and BRU into one-entry per-unit buffers.
- Arbitrates the buffered results round-robin onto two result broadcast (CDB) ports, which feed the ROB and the wakeup logic.
- Reports branch resolution on a dedicated port and back-pressures each execute unit with a ready signal.
- AGU output is not handled here; it goes to the LSU.

---
 rtl/wb_stage.sv | 227 ++++++++++++++++++++++
 tb/tb_wb_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage
//  Description : Writeback stage. Buffers ALU/SFU/BRU results one entry per
//                unit, arbitrates them round-robin onto two CDB ports and
//                reports branch resolution when the BRU result is broadcast.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_stage #(
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              alu_valid,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              alu_ovf,
    output logic              alu_ready,
    input  logic              sfu_valid,
    input  logic [TAG_W-1:0]  sfu_tag,
    input  logic [DATA_W-1:0] sfu_data,
    output logic              sfu_ready,
    input  logic              bru_valid,
    input  logic [TAG_W-1:0]  bru_tag,
    input  logic [DATA_W-1:0] bru_data,
    input  logic              bru_pre_right,
    input  logic              bru_b_type,
    input  logic              bru_real_dir,
    input  logic [DATA_W-1:0] bru_addr,
    output logic              bru_ready,
    output logic              cdb0_valid,
    output logic [TAG_W-1:0]  cdb0_tag,
    output logic [DATA_W-1:0] cdb0_data,
    output logic              cdb0_exc,
    output logic              cdb1_valid,
    output logic [TAG_W-1:0]  cdb1_tag,
    output logic [DATA_W-1:0] cdb1_data,
    output logic              cdb1_exc,
    output logic              br_valid,
    output logic [TAG_W-1:0]  br_tag,
    output logic              br_mispredict,
    output logic              br_b_type,
    output logic              br_real_dir,
    output logic [DATA_W-1:0] br_addr
);

    localparam logic [1:0] c_SRC_ALU = 2'd0;
    localparam logic [1:0] c_SRC_SFU = 2'd1;
    localparam logic [1:0] c_SRC_BRU = 2'd2;

    // Next source in the ALU -> SFU -> BRU -> ALU rotation (3 folds back to ALU).
    function automatic logic [1:0] f_next_src(input logic [1:0] src);
        return (src == c_SRC_BRU) ? c_SRC_ALU : src + 2'd1;
    endfunction

    logic              r_alu_full, r_sfu_full, r_bru_full;
    logic [TAG_W-1:0]  r_alu_tag, r_sfu_tag, r_bru_tag;
    logic [DATA_W-1:0] r_alu_data, r_sfu_data, r_bru_data, r_bru_addr;
    logic              r_alu_ovf, r_bru_pre_right, r_bru_b_type, r_bru_real_dir;
    logic [1:0]        r_rr;

    logic [3:0] w_full;
    logic [1:0] w_scan;
    logic       w_g0_vld, w_g1_vld;
    logic [1:0] w_g0_src, w_g1_src;
    logic       w_gnt_alu, w_gnt_sfu, w_gnt_bru;
    logic       w_alu_acc, w_sfu_acc, w_bru_acc;
    logic       w_out_en;

    // Round-robin scan from r_rr: first full buffer wins port 0, second wins port 1.
    always_comb begin
        w_full   = {1'b0, r_bru_full, r_sfu_full, r_alu_full};
        w_g0_vld = 1'b0;
        w_g0_src = c_SRC_ALU;
        w_g1_vld = 1'b0;
        w_g1_src = c_SRC_ALU;
        w_scan   = (r_rr == 2'd3) ? c_SRC_ALU : r_rr;
        for (int k = 0; k < 3; k++) begin
            if (w_full[w_scan]) begin
                if (!w_g0_vld) begin
                    w_g0_vld = 1'b1;
                    w_g0_src = w_scan;
                end else if (!w_g1_vld) begin
                    w_g1_vld = 1'b1;
                    w_g1_src = w_scan;
                end
            end
            w_scan = f_next_src(w_scan);
        end
    end

    assign w_gnt_alu = (w_g0_vld && w_g0_src == c_SRC_ALU) || (w_g1_vld && w_g1_src == c_SRC_ALU);
    assign w_gnt_sfu = (w_g0_vld && w_g0_src == c_SRC_SFU) || (w_g1_vld && w_g1_src == c_SRC_SFU);
    assign w_gnt_bru = (w_g0_vld && w_g0_src == c_SRC_BRU) || (w_g1_vld && w_g1_src == c_SRC_BRU);

    // A buffer can take a new result if it is empty or is draining this cycle.
    assign alu_ready = rst_n && (!r_alu_full || w_gnt_alu);
    assign sfu_ready = rst_n && (!r_sfu_full || w_gnt_sfu);
    assign bru_ready = rst_n && (!r_bru_full || w_gnt_bru);

    assign w_alu_acc = alu_valid && alu_ready;
    assign w_sfu_acc = sfu_valid && sfu_ready;
    assign w_bru_acc = bru_valid && bru_ready;

    // Broadcasts are suppressed in reset and during a flush cycle.
    assign w_out_en = rst_n && !flush;

    // Drive both CDB ports from the granted buffers.
    always_comb begin
        cdb0_valid = 1'b0;
        cdb0_tag   = '0;
        cdb0_data  = '0;
        cdb0_exc   = 1'b0;
        cdb1_valid = 1'b0;
        cdb1_tag   = '0;
        cdb1_data  = '0;
        cdb1_exc   = 1'b0;
        if (w_out_en && w_g0_vld) begin
            cdb0_valid = 1'b1;
            case (w_g0_src)
                c_SRC_ALU: begin cdb0_tag = r_alu_tag; cdb0_data = r_alu_data; cdb0_exc = r_alu_ovf; end
                c_SRC_SFU: begin cdb0_tag = r_sfu_tag; cdb0_data = r_sfu_data; end
                default:   begin cdb0_tag = r_bru_tag; cdb0_data = r_bru_data; end
            endcase
        end
        if (w_out_en && w_g1_vld) begin
            cdb1_valid = 1'b1;
            case (w_g1_src)
                c_SRC_ALU: begin cdb1_tag = r_alu_tag; cdb1_data = r_alu_data; cdb1_exc = r_alu_ovf; end
                c_SRC_SFU: begin cdb1_tag = r_sfu_tag; cdb1_data = r_sfu_data; end
                default:   begin cdb1_tag = r_bru_tag; cdb1_data = r_bru_data; end
            endcase
        end
    end

    // Branch resolution rides along with the BRU broadcast on whichever port.
    always_comb begin
        br_valid      = 1'b0;
        br_tag        = '0;
        br_mispredict = 1'b0;
        br_b_type     = 1'b0;
        br_real_dir   = 1'b0;
        br_addr       = '0;
        if (w_out_en && w_gnt_bru) begin
            br_valid      = 1'b1;
            br_tag        = r_bru_tag;
            br_mispredict = !r_bru_pre_right;
            br_b_type     = r_bru_b_type;
            br_real_dir   = r_bru_real_dir;
            br_addr       = r_bru_addr;
        end
    end

    // ALU buffer: capture on handshake, otherwise drain when granted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alu_full <= 1'b0;
            r_alu_tag  <= '0;
            r_alu_data <= '0;
            r_alu_ovf  <= 1'b0;
        end else if (flush) begin
            r_alu_full <= 1'b0;
        end else if (w_alu_acc) begin
            r_alu_full <= 1'b1;
            r_alu_tag  <= alu_tag;
            r_alu_data <= alu_data;
            r_alu_ovf  <= alu_ovf;
        end else if (w_gnt_alu) begin
            r_alu_full <= 1'b0;
        end
    end

    // SFU buffer: capture on handshake, otherwise drain when granted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sfu_full <= 1'b0;
            r_sfu_tag  <= '0;
            r_sfu_data <= '0;
        end else if (flush) begin
            r_sfu_full <= 1'b0;
        end else if (w_sfu_acc) begin
            r_sfu_full <= 1'b1;
            r_sfu_tag  <= sfu_tag;
            r_sfu_data <= sfu_data;
        end else if (w_gnt_sfu) begin
            r_sfu_full <= 1'b0;
        end
    end

    // BRU buffer: capture result plus branch info, drain when granted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bru_full      <= 1'b0;
            r_bru_tag       <= '0;
            r_bru_data      <= '0;
            r_bru_pre_right <= 1'b0;
            r_bru_b_type    <= 1'b0;
            r_bru_real_dir  <= 1'b0;
            r_bru_addr      <= '0;
        end else if (flush) begin
            r_bru_full <= 1'b0;
        end else if (w_bru_acc) begin
            r_bru_full      <= 1'b1;
            r_bru_tag       <= bru_tag;
            r_bru_data      <= bru_data;
            r_bru_pre_right <= bru_pre_right;
            r_bru_b_type    <= bru_b_type;
            r_bru_real_dir  <= bru_real_dir;
            r_bru_addr      <= bru_addr;
        end else if (w_gnt_bru) begin
            r_bru_full <= 1'b0;
        end
    end

    // Round-robin pointer moves just past the last source granted this cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_rr <= c_SRC_ALU;
        end else if (w_g0_vld) begin
            r_rr <= f_next_src(w_g1_vld ? w_g1_src : w_g0_src);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_stage
//  Description : Directed, table-driven self-checking bench for wb_stage.
//                Each row gives one cycle of inputs and the outputs expected
//                during that same cycle (before the closing clock edge).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush;
    logic        alu_valid, alu_ovf, alu_ready;
    logic [5:0]  alu_tag;
    logic [31:0] alu_data;
    logic        sfu_valid, sfu_ready;
    logic [5:0]  sfu_tag;
    logic [31:0] sfu_data;
    logic        bru_valid, bru_pre_right, bru_b_type, bru_real_dir, bru_ready;
    logic [5:0]  bru_tag;
    logic [31:0] bru_data, bru_addr;
    logic        cdb0_valid, cdb0_exc, cdb1_valid, cdb1_exc;
    logic [5:0]  cdb0_tag, cdb1_tag;
    logic [31:0] cdb0_data, cdb1_data;
    logic        br_valid, br_mispredict, br_b_type, br_real_dir;
    logic [5:0]  br_tag;
    logic [31:0] br_addr;

    always #5 clk = ~clk;

    wb_stage #(.TAG_W(6), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_data(alu_data),
        .alu_ovf(alu_ovf), .alu_ready(alu_ready),
        .sfu_valid(sfu_valid), .sfu_tag(sfu_tag), .sfu_data(sfu_data),
        .sfu_ready(sfu_ready),
        .bru_valid(bru_valid), .bru_tag(bru_tag), .bru_data(bru_data),
        .bru_pre_right(bru_pre_right), .bru_b_type(bru_b_type),
        .bru_real_dir(bru_real_dir), .bru_addr(bru_addr), .bru_ready(bru_ready),
        .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
        .cdb0_exc(cdb0_exc),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
        .cdb1_exc(cdb1_exc),
        .br_valid(br_valid), .br_tag(br_tag), .br_mispredict(br_mispredict),
        .br_b_type(br_b_type), .br_real_dir(br_real_dir), .br_addr(br_addr)
    );

    typedef struct packed {
        logic        av; logic [5:0] at; logic [31:0] ad; logic ao;
        logic        sv; logic [5:0] st; logic [31:0] sd;
        logic        bv; logic [5:0] bt; logic [31:0] bd;
        logic        bpr; logic bbt; logic bdir; logic [31:0] ba;
    } vin_t;

    typedef struct packed {
        logic [2:0]  rdy;   // {alu, sfu, bru}
        logic        c0v; logic [5:0] c0t; logic [31:0] c0d; logic c0e;
        logic        c1v; logic [5:0] c1t; logic [31:0] c1d; logic c1e;
        logic        brv; logic [5:0] brt; logic brm; logic brb; logic brd;
        logic [31:0] bra;
    } vexp_t;

    typedef struct {
        string name;
        logic  rst_n;
        logic  flush;
        vin_t  vi;
        vexp_t ve;
    } row_t;

    row_t rows[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    vin_t  NONE = '0;

    function automatic vin_t ia(input logic [5:0] t, input logic [31:0] d, input logic o);
        vin_t v = '0;
        v.av = 1'b1; v.at = t; v.ad = d; v.ao = o;
        return v;
    endfunction

    function automatic vin_t is(input logic [5:0] t, input logic [31:0] d);
        vin_t v = '0;
        v.sv = 1'b1; v.st = t; v.sd = d;
        return v;
    endfunction

    function automatic vin_t ib(input logic [5:0] t, input logic [31:0] d, input logic pr,
                                input logic btp, input logic dir, input logic [31:0] a);
        vin_t v = '0;
        v.bv = 1'b1; v.bt = t; v.bd = d; v.bpr = pr; v.bbt = btp; v.bdir = dir; v.ba = a;
        return v;
    endfunction

    function automatic vexp_t er(input logic a, input logic s, input logic b);
        vexp_t e = '0;
        e.rdy = {a, s, b};
        return e;
    endfunction

    function automatic vexp_t ec0(input logic [5:0] t, input logic [31:0] d, input logic x);
        vexp_t e = '0;
        e.c0v = 1'b1; e.c0t = t; e.c0d = d; e.c0e = x;
        return e;
    endfunction

    function automatic vexp_t ec1(input logic [5:0] t, input logic [31:0] d, input logic x);
        vexp_t e = '0;
        e.c1v = 1'b1; e.c1t = t; e.c1d = d; e.c1e = x;
        return e;
    endfunction

    function automatic vexp_t ebr(input logic [5:0] t, input logic m, input logic b,
                                  input logic dir, input logic [31:0] a);
        vexp_t e = '0;
        e.brv = 1'b1; e.brt = t; e.brm = m; e.brb = b; e.brd = dir; e.bra = a;
        return e;
    endfunction

    task automatic add(input string n, input logic r, input logic f, input vin_t vi, input vexp_t ve);
        row_t x;
        x.name = n; x.rst_n = r; x.flush = f; x.vi = vi; x.ve = ve;
        rows.push_back(x);
    endtask

    task automatic drive(input row_t r);
        rst_n         = r.rst_n;
        flush         = r.flush;
        alu_valid     = r.vi.av;  alu_tag = r.vi.at; alu_data = r.vi.ad; alu_ovf = r.vi.ao;
        sfu_valid     = r.vi.sv;  sfu_tag = r.vi.st; sfu_data = r.vi.sd;
        bru_valid     = r.vi.bv;  bru_tag = r.vi.bt; bru_data = r.vi.bd;
        bru_pre_right = r.vi.bpr; bru_b_type = r.vi.bbt; bru_real_dir = r.vi.bdir;
        bru_addr      = r.vi.ba;
    endtask

    task automatic check(input string n, input string what, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s/%s: got %h, expected %h", n, what, act, exp);
        end
    endtask

    task automatic compare(input row_t r);
        vexp_t a;
        a.rdy = {alu_ready, sfu_ready, bru_ready};
        a.c0v = cdb0_valid; a.c0t = cdb0_tag; a.c0d = cdb0_data; a.c0e = cdb0_exc;
        a.c1v = cdb1_valid; a.c1t = cdb1_tag; a.c1d = cdb1_data; a.c1e = cdb1_exc;
        a.brv = br_valid; a.brt = br_tag; a.brm = br_mispredict; a.brb = br_b_type;
        a.brd = br_real_dir; a.bra = br_addr;
        check(r.name, "ready", 64'(a.rdy), 64'(r.ve.rdy));
        check(r.name, "cdb0", 64'({a.c0v, a.c0t, a.c0d, a.c0e}),
              64'({r.ve.c0v, r.ve.c0t, r.ve.c0d, r.ve.c0e}));
        check(r.name, "cdb1", 64'({a.c1v, a.c1t, a.c1d, a.c1e}),
              64'({r.ve.c1v, r.ve.c1t, r.ve.c1d, r.ve.c1e}));
        check(r.name, "br", 64'({a.brv, a.brt, a.brm, a.brb, a.brd, a.bra}),
              64'({r.ve.brv, r.ve.brt, r.ve.brm, r.ve.brb, r.ve.brd, r.ve.bra}));
    endtask

    initial begin
        // Reset with every unit presenting a result: nothing visible, no readys.
        add("rst0", 0, 0, vin_t'(ia(1, 32'h11, 1) | is(2, 32'h22) | ib(3, 32'h33, 1, 1, 1, 32'h3)), er(0, 0, 0));
        add("rst1", 0, 0, vin_t'(ia(1, 32'h11, 1) | is(2, 32'h22) | ib(3, 32'h33, 1, 1, 1, 32'h3)), er(0, 0, 0));
        add("rst_rel", 1, 0, NONE, er(1, 1, 1));
        // Single ALU result, one-cycle latency, overflow carried as exception.
        add("alu_in",  1, 0, ia(5, 32'h0000_1234, 1), er(1, 1, 1));
        add("alu_out", 1, 0, NONE, vexp_t'(er(1, 1, 1) | ec0(5, 32'h0000_1234, 1)));
        // Mispredicted branch (rr=1 here; BRU alone wins port 0, rr returns to 0).
        add("bru_in",  1, 0, ib(9, 32'h55, 0, 1, 1, 32'h80), er(1, 1, 1));
        add("bru_out", 1, 0, NONE, vexp_t'(er(1, 1, 1) | ec0(9, 32'h55, 0) | ebr(9, 1, 1, 1, 32'h80)));
        // Three-way contention from rr=0; held BRU input while bru_ready=0.
        add("cont_in", 1, 0, vin_t'(ia(1, 32'hA1, 0) | is(2, 32'hB2) | ib(3, 32'hC3, 1, 0, 0, 32'h100)), er(1, 1, 1));
        add("cont_1",  1, 0, ib(4, 32'hD4, 1, 1, 0, 32'h104),
            vexp_t'(er(1, 1, 0) | ec0(1, 32'hA1, 0) | ec1(2, 32'hB2, 0)));
        add("cont_2",  1, 0, ib(4, 32'hD4, 1, 1, 0, 32'h104),
            vexp_t'(er(1, 1, 1) | ec0(3, 32'hC3, 0) | ebr(3, 0, 0, 0, 32'h100)));
        add("cont_3",  1, 0, NONE, vexp_t'(er(1, 1, 1) | ec0(4, 32'hD4, 0) | ebr(4, 0, 1, 0, 32'h104)));
        add("cont_4",  1, 0, NONE, er(1, 1, 1));
        // Streaming ALU+SFU for 8 cycles: 16 broadcasts over 8 consecutive cycles.
        for (int k = 0; k < 8; k++) begin
            if (k == 0)
                add($sformatf("strm%0d", k), 1, 0,
                    vin_t'(ia(6'(16 + k), 32'h1000 + 32'(k), 0) | is(6'(32 + k), 32'h2000 + 32'(k))), er(1, 1, 1));
            else
                add($sformatf("strm%0d", k), 1, 0,
                    vin_t'(ia(6'(16 + k), 32'h1000 + 32'(k), 0) | is(6'(32 + k), 32'h2000 + 32'(k))),
                    vexp_t'(er(1, 1, 1) | ec0(6'(15 + k), 32'h1000 + 32'(k - 1), 0)
                                        | ec1(6'(31 + k), 32'h2000 + 32'(k - 1), 0)));
        end
        add("strm_drain", 1, 0, NONE, vexp_t'(er(1, 1, 1) | ec0(6'd23, 32'h1007, 0) | ec1(6'd39, 32'h2007, 0)));
        // Flush with all buffers full (rr=2) and a new ALU result presented.
        add("fl_fill",  1, 0, vin_t'(ia(6'h30, 32'h300, 1) | is(6'h31, 32'h310) | ib(6'h32, 32'h320, 1, 1, 1, 32'h3200)), er(1, 1, 1));
        add("fl_flush", 1, 1, ia(6'h33, 32'h330, 0), er(1, 0, 1));
        add("fl_after", 1, 0, NONE, er(1, 1, 1));
        // After flush rr must be 0: ALU then SFU win, BRU waits.
        add("fl_refill", 1, 0, vin_t'(ia(6'h40, 32'h400, 0) | is(6'h41, 32'h410) | ib(6'h42, 32'h420, 0, 0, 1, 32'h4200)), er(1, 1, 1));
        add("fl_rr0",   1, 0, NONE, vexp_t'(er(1, 1, 0) | ec0(6'h40, 32'h400, 0) | ec1(6'h41, 32'h410, 0)));
        add("fl_bru",   1, 0, NONE, vexp_t'(er(1, 1, 1) | ec0(6'h42, 32'h420, 0) | ebr(6'h42, 1, 0, 1, 32'h4200)));
        add("fl_empty", 1, 0, NONE, er(1, 1, 1));
        // ALU exception on port 1, then branch resolution from port 1.
        add("g_sfu",     1, 0, is(6'h60, 32'h600), er(1, 1, 1));
        add("g_sfu_out", 1, 0, vin_t'(ia(6'h61, 32'h610, 1) | ib(6'h62, 32'h620, 1, 1, 1, 32'h6200)),
            vexp_t'(er(1, 1, 1) | ec0(6'h60, 32'h600, 0)));
        add("g_bru_alu", 1, 0, NONE,
            vexp_t'(er(1, 1, 1) | ec0(6'h62, 32'h620, 0) | ebr(6'h62, 0, 1, 1, 32'h6200) | ec1(6'h61, 32'h610, 1)));
        add("g_fill2",   1, 0, vin_t'(is(6'h63, 32'h630) | ib(6'h64, 32'h640, 0, 1, 0, 32'h6400)), er(1, 1, 1));
        add("g_sfu_bru", 1, 0, NONE,
            vexp_t'(er(1, 1, 1) | ec0(6'h63, 32'h630, 0) | ec1(6'h64, 32'h640, 0) | ebr(6'h64, 1, 1, 0, 32'h6400)));
        // Reset mid-operation discards a buffered result.
        add("r_fill", 1, 0, ia(6'h50, 32'h500, 0), er(1, 1, 1));
        add("r_mid",  0, 0, NONE, er(0, 0, 0));
        add("r_rel",  1, 0, NONE, er(1, 1, 1));

        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i]);
            @(negedge clk);
            compare(rows[i]);
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
